gp_imem: RTL and testbench

Parametrised, writable instruction memory for the graphics processor, replacing the fixed boot ROM at the GP fetch port. On reset release a boot sequencer copies the default boot image into a flop-based RAM and clears the remainder. After that it serves fetches through a stallable registered address. A byte-enabled write port lets the host patch code at runtime, and a reload request restores the boot image without a full reset.

---
 rtl/gp_imem_pkg.sv | 28 ++
 rtl/gp_boot_seq.sv | 43 ++++
 rtl/gp_imem.sv | 81 ++++++++
 tb/tb_gp_imem.sv | 273 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/gp_imem_pkg.sv
// Shared constants for the GP instruction memory: default boot image and sequencer states.
package gp_imem_pkg;

  localparam int unsigned BOOT_LEN   = 28;
  localparam int unsigned BOOT_IDX_W = $clog2(BOOT_LEN);

  typedef enum logic {
    COPY  = 1'b0,
    READY = 1'b1
  } state_t;

  localparam logic [31:0] BOOT_IMAGE [BOOT_LEN] = '{
    32'h3c1d1000, 32'h37bd0ffc, 32'h3c080000, 32'h35080100,
    32'h3c09dead, 32'had090000, 32'h8d0a0000, 32'h3c090123,
    32'h35294567, 32'had090004, 32'h8d0b0004, 32'h240c0010,
    32'h01806821, 32'h25adffff, 32'h15a0fffe, 32'h00000000,
    32'h3c0e0000, 32'h35ce0200, 32'hadcc0000, 32'h8dcf0000,
    32'h01ec8021, 32'hae100008, 32'h24110001, 32'hae110010,
    32'h00000000, 32'h3c1f0000, 32'h01800008, 32'h00000000
  };

  // Words past the image read as zero so the copy clears the rest of the RAM.
  function automatic logic [31:0] boot_word(input logic [31:0] i);
    boot_word = 32'h0;
    if (i < BOOT_LEN) boot_word = BOOT_IMAGE[i[BOOT_IDX_W-1:0]];
  endfunction

endpackage

// File: rtl/gp_boot_seq.sv
// Boot sequencer: walks every RAM word once after reset or a reload request,
// supplying the image word (or zero) to write, then parks in READY.
module gp_boot_seq
  import gp_imem_pkg::*;
#(
  parameter int DEPTH  = 64,
  parameter int DATA_W = 32,
  localparam int IDX_W = $clog2(DEPTH) + 1,
  localparam int MEM_AW = (DEPTH > 1) ? $clog2(DEPTH) : 1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              boot_req,
  output logic              ready,
  output logic              copy_we,
  output logic [MEM_AW-1:0] copy_addr,
  output logic [DATA_W-1:0] copy_data
);

  localparam logic [IDX_W-1:0] LAST = IDX_W'(DEPTH - 1);

  state_t           state;
  logic [IDX_W-1:0] idx;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state <= COPY;
      idx   <= '0;
    end else if (state == COPY) begin
      idx <= idx + 1'b1;
      if (idx == LAST) state <= READY;
    end else if (boot_req) begin
      state <= COPY;
      idx   <= '0;
    end
  end

  assign ready     = (state == READY);
  assign copy_we   = (state == COPY);
  assign copy_addr = idx[MEM_AW-1:0];
  assign copy_data = DATA_W'(boot_word(32'(idx)));

endmodule

// File: rtl/gp_imem.sv
// Writable GP instruction memory: boot-loaded flop RAM with a stallable registered
// fetch address, byte-enabled host write port and in-place boot image reload.
module gp_imem
  import gp_imem_pkg::*;
#(
  parameter int DATA_W = 32,
  parameter int ADDR_W = 30,
  parameter int DEPTH  = 64
) (
  input  logic                clk,
  input  logic                rst,
  input  logic [ADDR_W-1:0]   addr,
  input  logic                stall,
  output logic [DATA_W-1:0]   inst,
  output logic                inst_valid,
  input  logic                we,
  input  logic [ADDR_W-1:0]   waddr,
  input  logic [DATA_W-1:0]   wdata,
  input  logic [DATA_W/8-1:0] wbe,
  output logic                wr_err,
  input  logic                boot_req,
  output logic                ready
);

  localparam int NB     = DATA_W / 8;
  localparam int MEM_AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [ADDR_W:0] DEPTH_A = (ADDR_W + 1)'(DEPTH);

  logic [DATA_W-1:0] mem [DEPTH];
  logic [ADDR_W-1:0] addr_r;
  logic              copy_we;
  logic [MEM_AW-1:0] copy_addr;
  logic [DATA_W-1:0] copy_data;
  logic              waddr_ok;
  logic              wr_acc;
  logic              rd_hit;

  gp_boot_seq #(
    .DEPTH (DEPTH),
    .DATA_W(DATA_W)
  ) u_boot_seq (
    .clk      (clk),
    .rst      (rst),
    .boot_req (boot_req),
    .ready    (ready),
    .copy_we  (copy_we),
    .copy_addr(copy_addr),
    .copy_data(copy_data)
  );

  // A write racing a reload is dropped: the copy would overwrite it anyway.
  assign waddr_ok = {1'b0, waddr} < DEPTH_A;
  assign wr_acc   = ready && we && !boot_req && waddr_ok;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      addr_r <= '0;
      wr_err <= 1'b0;
    end else begin
      wr_err <= we && !wr_acc;
      if (!ready || boot_req) addr_r <= '0;
      else if (!stall)        addr_r <= addr;
    end
  end

  always_ff @(posedge clk) begin
    if (copy_we) begin
      mem[copy_addr] <= copy_data;
    end else if (wr_acc) begin
      for (int j = 0; j < NB; j++) begin
        if (wbe[j]) mem[waddr[MEM_AW-1:0]][8*j +: 8] <= wdata[8*j +: 8];
      end
    end
  end

  // Read is combinational from the RAM so a same-edge write is seen immediately.
  assign rd_hit     = ready && ({1'b0, addr_r} < DEPTH_A);
  assign inst       = rd_hit ? mem[addr_r[MEM_AW-1:0]] : '0;
  assign inst_valid = ready;

endmodule

// File: tb/tb_gp_imem.sv
// Scoreboard bench for gp_imem: randomized and directed stimulus against a word-level memory model.
module tb_gp_imem;

  localparam int DEPTH = 64;

  localparam logic [31:0] TB_IMG [28] = '{
    32'h3c1d1000, 32'h37bd0ffc, 32'h3c080000, 32'h35080100,
    32'h3c09dead, 32'had090000, 32'h8d0a0000, 32'h3c090123,
    32'h35294567, 32'had090004, 32'h8d0b0004, 32'h240c0010,
    32'h01806821, 32'h25adffff, 32'h15a0fffe, 32'h00000000,
    32'h3c0e0000, 32'h35ce0200, 32'hadcc0000, 32'h8dcf0000,
    32'h01ec8021, 32'hae100008, 32'h24110001, 32'hae110010,
    32'h00000000, 32'h3c1f0000, 32'h01800008, 32'h00000000
  };

  typedef struct packed {
    logic [31:0] inst;
    logic        v;
    logic        r;
    logic        e;
  } exp_t;

  logic        clk = 1'b0;
  logic        rst_n = 1'b1;
  logic [29:0] addr = '0;
  logic        stall = 1'b0;
  logic [31:0] inst;
  logic        inst_valid;
  logic        we = 1'b0;
  logic [29:0] waddr = '0;
  logic [31:0] wdata = '0;
  logic [3:0]  wbe = '0;
  logic        wr_err;
  logic        boot_req = 1'b0;
  logic        ready;

  int tests = 0;
  int fails = 0;

  exp_t q[$];
  exp_t got_e;

  // Reference model state: whole-memory view, copy modelled as a countdown.
  logic [31:0] m_mem [DEPTH];
  logic        m_ready;
  int          m_left;
  logic [29:0] m_addr_r;
  logic        m_err;

  gp_imem dut (
    .clk       (clk),
    .rst       (rst_n),
    .addr      (addr),
    .stall     (stall),
    .inst      (inst),
    .inst_valid(inst_valid),
    .we        (we),
    .waddr     (waddr),
    .wdata     (wdata),
    .wbe       (wbe),
    .wr_err    (wr_err),
    .boot_req  (boot_req),
    .ready     (ready)
  );

  always #5 clk = ~clk;

  function automatic exp_t model_out();
    exp_t o;
    o.inst = (m_ready && m_addr_r < DEPTH) ? m_mem[m_addr_r[5:0]] : 32'h0;
    o.v    = m_ready;
    o.r    = m_ready;
    o.e    = m_err;
    return o;
  endfunction

  task automatic model_reset();
    m_ready  = 1'b0;
    m_left   = DEPTH;
    m_addr_r = '0;
    m_err    = 1'b0;
  endtask

  task automatic model_edge();
    logic acc;
    if (!rst_n) begin
      model_reset();
      return;
    end
    acc   = m_ready && we && !boot_req && (waddr < DEPTH);
    m_err = we && !acc;
    if (m_ready) begin
      if (boot_req) begin
        m_ready  = 1'b0;
        m_left   = DEPTH;
        m_addr_r = '0;
      end else begin
        if (acc)
          for (int j = 0; j < 4; j++)
            if (wbe[j]) m_mem[waddr[5:0]][8*j +: 8] = wdata[8*j +: 8];
        if (!stall) m_addr_r = addr;
      end
    end else begin
      m_addr_r = '0;
      m_left   = m_left - 1;
      if (m_left == 0) begin
        for (int k = 0; k < DEPTH; k++) m_mem[k] = (k < 28) ? TB_IMG[k] : 32'h0;
        m_ready = 1'b1;
      end
    end
  endtask

  // Call before the next rising edge with inputs already driven; returns at the following falling edge.
  task automatic step();
    model_edge();
    q.push_back(model_out());
    @(negedge clk);
  endtask

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    tests++;
    if (got !== exp) begin
      fails++;
      $display("FAIL %s: got %h, expected %h", name, got, exp);
    end
  endtask

  task automatic idle();
    we = 1'b0; boot_req = 1'b0; stall = 1'b0; wbe = '0; wdata = '0; waddr = '0;
  endtask

  task automatic wait_ready(input string name);
    int n;
    n = 0;
    do begin
      step();
      n++;
    end while (ready !== 1'b1 && n < 200);
    check(name, 32'(n), 32'd64);
  endtask

  task automatic assert_reset();
    model_reset();
    q.push_back(model_out());
    rst_n = 1'b0;
    #2;
  endtask

  // Monitor: one expected entry per rising edge and per reset assertion.
  initial begin
    #3;
    forever begin
      @(posedge clk or negedge rst_n);
      #1;
      tests++;
      if (q.size() == 0) begin
        fails++;
        $display("FAIL scoreboard_empty: DUT output with no expected entry at %0t", $time);
      end else begin
        got_e = q.pop_front();
        if ({inst, inst_valid, ready, wr_err} !== {got_e.inst, got_e.v, got_e.r, got_e.e}) begin
          fails++;
          $display("FAIL cycle_check @%0t: got inst=%h valid=%b ready=%b wr_err=%b, expected inst=%h valid=%b ready=%b wr_err=%b",
                   $time, inst, inst_valid, ready, wr_err, got_e.inst, got_e.v, got_e.r, got_e.e);
        end
      end
    end
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish, %0d tests run, %0d failed", tests, fails);
    $fatal(1, "timeout");
  end

  initial begin
    for (int k = 0; k < DEPTH; k++) m_mem[k] = 32'h0;
    model_reset();

    #1 rst_n = 1'b0;
    #1;
    check("reset_inst", inst, 32'h0);
    check("reset_flags", {28'h0, inst_valid, ready, wr_err, 1'b0}, 32'h0);
    repeat (3) step();

    // Boot after release
    rst_n = 1'b1;
    wait_ready("boot_latency");
    check("first_inst_word0", inst, 32'h3c1d1000);
    addr = 30'h1a;  step(); check("read_1a", inst, 32'h01800008);
    addr = 30'h30;  step(); check("read_30_cleared", inst, 32'h0);
    addr = 30'h100; step(); check("read_out_of_range", inst, 32'h0);
    addr = 30'h3fffffff; step(); check("read_max_addr", inst, 32'h0);

    // Stall
    addr = 30'd5; step(); check("stall_pre", inst, 32'had090000);
    stall = 1'b1; addr = 30'd7;
    repeat (3) begin step(); check("stall_hold", inst, 32'had090000); end
    stall = 1'b0; step(); check("stall_release", inst, 32'h3c090123);

    // Byte writes under the fetched word
    addr = 30'h20; step();
    we = 1'b1; waddr = 30'h20; wdata = 32'hdeadbeef; wbe = 4'b0011;
    step(); check("bytewrite_low", inst, 32'h0000beef);
    wbe = 4'b1100; step(); check("bytewrite_high", inst, 32'hdeadbeef);
    wbe = 4'b0000; wdata = 32'h12345678; step();
    check("wbe_zero_noop", inst, 32'hdeadbeef); check("wbe_zero_no_err", 32'(wr_err), 32'h0);
    addr = 30'h21; waddr = 30'h21; wbe = 4'hf; step(); check("same_cycle_fetch_write", inst, 32'h12345678);

    // Out-of-range write drop
    waddr = 30'd64; wdata = 32'hffffffff; step(); check("drop_range_err", 32'(wr_err), 32'h1);
    idle(); step(); check("drop_range_err_clear", 32'(wr_err), 32'h0);
    for (int a = 0; a < DEPTH; a++) begin addr = 30'(a); step(); end

    // Patch word 0, then reload with a colliding write
    we = 1'b1; waddr = 30'h0; wdata = 32'h11111111; wbe = 4'hf; addr = 30'h0;
    step(); check("patch_word0", inst, 32'h11111111);
    waddr = 30'h3; wdata = 32'hcafef00d; boot_req = 1'b1;
    step(); check("drop_with_boot_err", 32'(wr_err), 32'h1); check("reload_inst_zero", inst, 32'h0);
    idle();
    repeat (9) step();
    we = 1'b1; step(); check("drop_copy_err", 32'(wr_err), 32'h1);
    we = 1'b0; check("copy_not_ready", 32'(ready), 32'h0);
    begin
      int n;
      n = 10;
      do begin step(); n++; end while (ready !== 1'b1 && n < 200);
      check("reload_latency", 32'(n), 32'd64);
    end
    check("reload_word0", inst, 32'h3c1d1000);
    addr = 30'h20; step(); check("reload_word20", inst, 32'h0);
    addr = 30'h3;  step(); check("reload_lost_write", inst, 32'h35080100);

    // Reset in the middle of a copy
    boot_req = 1'b1; step(); boot_req = 1'b0;
    repeat (29) step();
    we = 1'b1; step(); we = 1'b0;
    check("midcopy_err_before_rst", 32'(wr_err), 32'h1);
    assert_reset();
    check("midcopy_rst_err", 32'(wr_err), 32'h0);
    check("midcopy_rst_inst", inst, 32'h0);
    repeat (2) step();
    rst_n = 1'b1;
    wait_ready("midcopy_boot_latency");
    for (int a = 0; a < DEPTH; a++) begin addr = 30'(a); step(); end

    // Randomized traffic
    for (int i = 0; i < 600; i++) begin
      addr     = ($urandom_range(0, 9) == 0) ? 30'($urandom) : 30'($urandom_range(0, 70));
      stall    = ($urandom_range(0, 3) == 0);
      we       = ($urandom_range(0, 2) == 0);
      waddr    = 30'($urandom_range(0, 70));
      wdata    = $urandom;
      wbe      = 4'($urandom);
      boot_req = ($urandom_range(0, 99) == 0);
      step();
    end
    idle();
    begin
      int n;
      n = 0;
      while (ready !== 1'b1 && n < 200) begin step(); n++; end
      check("random_end_ready", 32'(ready), 32'h1);
    end
    for (int a = 0; a < DEPTH; a++) begin addr = 30'(a); step(); end

    #2;
    check("scoreboard_drained", 32'(q.size()), 32'h0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
